// File: rtl/fifo_wrt_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wrt_arbiter
//
// Round-robin arbiter sharing the write port of an async FIFO among NUM_REQ
// requesters in the write clock domain. A grant is held for one packet, which
// ends on req_last or after MAX_BURST accepted beats. The FIFO's registered
// full flag back-pressures the current owner.
//
// Ports
//   wrt_clk    in   write-domain clock, all logic on posedge
//   wrt_rst    in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]         per-requester beat valid
//   req_data   in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_last   in   [NUM_REQ]         final beat of the requester's packet
//   req_ready  out  [NUM_REQ]         beat accepted when valid & ready
//   full       in   FIFO full flag (registered, write domain)
//   wrt_en     out  FIFO write enable
//   wrt_data   out  [DATA_W] FIFO write data
//   grant      out  [NUM_REQ] one-hot current owner, 0 when idle
//   busy       out  1 while a requester owns the write port
// -----------------------------------------------------------------------------
module fifo_wrt_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      wrt_clk,
    input  logic                      wrt_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      full,
    output logic                      wrt_en,
    output logic [DATA_W-1:0]         wrt_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt;
    logic [IDX_W-1:0]     last_owner, last_owner_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;

    logic                 accept;
    logic                 pkt_done;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W:0]       scan;

    // Datapath towards the FIFO and requesters. Only the owner's beat can
    // reach the FIFO, and nothing is written while full is high.
    always_comb begin
        busy      = (state == OWN);
        accept    = busy & req_valid[owner] & ~full;
        pkt_done  = accept & (req_last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1)));
        wrt_en    = accept;
        wrt_data  = req_data[owner*DATA_W +: DATA_W];
        req_ready = grant & {NUM_REQ{~full}};
    end

    // Round-robin pick: scan last_owner+1, +2, ... (mod NUM_REQ). The previous
    // owner is checked last, so it loses to any other valid requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ))
                scan = scan - (IDX_W+1)'(NUM_REQ);
            if (!pick_found && req_valid[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_nxt      = state;
        owner_nxt      = owner;
        grant_nxt      = grant;
        beat_cnt_nxt   = beat_cnt;
        last_owner_nxt = last_owner;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = OWN;
                    owner_nxt    = pick_idx;
                    grant_nxt    = NUM_REQ'(1) << pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            OWN: begin
                // While stalled (no accept) everything stays frozen.
                if (accept)
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                if (pkt_done) begin
                    state_nxt      = IDLE;
                    grant_nxt      = '0;
                    last_owner_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers. last_owner resets to NUM_REQ-1 so requester 0 wins
    // the first arbitration.
    always_ff @(posedge wrt_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (wrt_rst) begin
            state      <= IDLE;
            owner      <= '0;
            grant      <= '0;
            beat_cnt   <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            grant      <= grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wrt_arbiter
//
// Randomised and directed stimulus for fifo_wrt_arbiter. Requesters hold a
// queue of packet beats; a packet-level reference model decides ownership
// and predicts each FIFO write, which is pushed into a scoreboard queue. A
// separate monitor pops the scoreboard whenever the DUT writes.
// -----------------------------------------------------------------------------
module tb_fifo_wrt_arbiter;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 8;

    logic              wrt_clk = 1'b0;
    logic              wrt_rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      req_ready;
    logic              full = 1'b0;
    logic              wrt_en;
    logic [DW-1:0]     wrt_data;
    logic [N-1:0]      grant;
    logic              busy;

    fifo_wrt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
        .wrt_clk   (wrt_clk),
        .wrt_rst   (wrt_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .full      (full),
        .wrt_en    (wrt_en),
        .wrt_data  (wrt_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wrt_clk = ~wrt_clk;

    typedef struct {
        int          id;
        logic [7:0]  data;
    } wr_t;

    wr_t         sb_q[$];
    logic [8:0]  beats[N][$];     // {last, data} per requester
    bit          pres[N];         // requester currently presenting a beat
    bit          drop[N];         // requester may not raise a new beat
    int          vpct     = 100;
    int          full_pct = 0;
    bit          full_force = 0;
    bit          rst_req  = 0;

    // Reference model: owner index (-1 = idle), beats taken this grant,
    // previous owner.
    int          m_owner = -1;
    int          m_cnt   = 0;
    int          m_last  = N - 1;

    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_packet(input int id, input int len);
        for (int b = 1; b <= len; b++)
            beats[id].push_back({(b == len), 8'($urandom)});
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && beats[i].size() != 0 && !drop[i] && $urandom_range(99) < vpct)
                pres[i] = 1'b1;
            req_valid[i] = pres[i];
            if (pres[i]) begin
                req_data[i*DW +: DW] = beats[i][0][7:0];
                req_last[i]          = beats[i][0][8];
            end else begin
                req_data[i*DW +: DW] = 8'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
        full    = full_force || ($urandom_range(99) < full_pct);
        wrt_rst = rst_req;
    endtask

    // Predict this cycle's outputs, record the expected write, then advance
    // the model to the state after the coming clock edge.
    task automatic model_step();
        int          o;
        bit          acc;
        bit          lastb;
        logic [N-1:0] eg;
        o     = m_owner;
        eg    = (o < 0) ? '0 : N'(1 << o);
        check("grant", grant, eg);
        check("busy", busy, (o >= 0));
        check("req_ready", req_ready, full ? '0 : eg);
        acc   = (o >= 0) && pres[o] && !full;
        lastb = 1'b0;
        if (acc) begin
            lastb = beats[o][0][8];
            sb_q.push_back('{o, beats[o][0][7:0]});
            void'(beats[o].pop_front());
            pres[o] = 1'b0;
            m_cnt++;
        end
        if (wrt_rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
        end else if (o < 0) begin
            for (int d = 1; d <= N; d++) begin
                int c;
                c = (m_last + d) % N;
                if (pres[c]) begin
                    m_owner = c;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (acc && (lastb || m_cnt == MAX_BURST)) begin
            m_last  = o;
            m_owner = -1;
        end
    endtask

    task automatic cycle();
        @(negedge wrt_clk);
        drive_inputs();
        #1;
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1;
        run(n);
        rst_req = 1'b0;
    endtask

    // Monitor: every DUT write must match the oldest predicted write, and no
    // predicted write may be left pending.
    initial begin
        wr_t e;
        forever begin
            @(negedge wrt_clk);
            #2;
            if (wrt_en) begin
                if (sb_q.size() == 0) begin
                    check("write_expected", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("wrt_data", wrt_data, e.data);
                    check("wrt_owner", grant, 32'(1 << e.id));
                end
            end
            check("pending_writes", 32'(sb_q.size()), 32'd0);
            if (sb_q.size() != 0) sb_q.delete();
        end
    end

    initial begin
        // Reset state, then a single 3-beat packet from requester 0.
        do_reset(2);
        add_packet(0, 3);
        run(8);

        // All four requesters with 1-beat packets: rotation 0,1,2,3,0,...
        do_reset(1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_packet(i, 1);
        run(20);

        // 20-beat packet: forced releases after beats 8 and 16.
        add_packet(1, 20);
        run(30);

        // Full for 5 cycles mid-packet.
        add_packet(2, 6);
        run(4);
        full_force = 1'b1;
        run(5);
        full_force = 1'b0;
        run(10);

        // Reset mid-packet; requester 1 then wins as lowest valid index.
        do_reset(1);
        add_packet(3, 6);
        run(3);
        add_packet(1, 2);
        run(1);
        do_reset(1);
        run(20);

        // Owner drops valid for 3 cycles while others request.
        do_reset(1);
        add_packet(0, 4);
        add_packet(1, 2);
        add_packet(2, 2);
        run(2);
        drop[0] = 1'b1;
        run(3);
        drop[0] = 1'b0;
        run(20);

        // Random traffic with random back-pressure.
        vpct     = 70;
        full_pct = 20;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 8) begin
                int id;
                id = $urandom_range(N - 1);
                if (beats[id].size() < 30) add_packet(id, $urandom_range(12, 1));
            end
            cycle();
        end

        // Drain.
        vpct     = 100;
        full_pct = 0;
        run(200);
        @(negedge wrt_clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
